clock_divider_ctrl: RTL and testbench



---
 rtl/clock_divider_ctrl_pkg.sv | 16 +
 rtl/clock_divider_ctrl_if.sv | 29 ++
 rtl/clock_div_counter.sv | 35 +++
 rtl/clock_divider_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_clock_divider_ctrl.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clock_divider_ctrl_pkg.sv
// Shared types and constants for the programmable clock-divide controller.
//   state_t       : controller state (IDLE / RUN / STOPPING)
//   DEFAULT_WIDTH : default width of the divide ratio and counter
//   DIV_ZERO      : the one illegal ratio value, rejected by the config port
package clock_divider_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DIV_ZERO      = 0;

endpackage

// File: rtl/clock_divider_ctrl_if.sv
// Configuration handshake bundle for clock_divider_ctrl.
//   cfg_valid : new half-period ratio offered      (master -> slave)
//   cfg_div   : requested half-period in clk cycles (master -> slave)
//   cfg_ready : controller can accept a ratio       (slave -> master)
//   cfg_err   : one-cycle pulse, zero ratio rejected (slave -> master)
interface clock_divider_ctrl_if
    import clock_divider_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             cfg_valid;
    logic [WIDTH-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;

    modport master (
        output cfg_valid,
        output cfg_div,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/clock_div_counter.sv
// Loadable down-counter with a zero flag; holds the remaining cycles of the
// current clk_out phase.
//   clk, rst_n : clock, asynchronous active-low reset (count clears to 0)
//   load       : load load_value (has priority over dec)
//   load_value : value to load
//   dec        : decrement by one
//   zero       : count is zero
module clock_div_counter
    import clock_divider_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (dec) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/clock_divider_ctrl.sv
// Runtime-programmable 50%-duty clock divider with glitch-free start/stop.
// Half-period ratio changes are deferred to the next rising edge of clk_out so
// every full period uses a single ratio.
//   clk, rst_n  : system clock, asynchronous active-low reset
//   en          : 1 = run divided clock, 0 = stop after the current low phase
//   cfg         : ratio handshake (slave side of clock_divider_ctrl_if)
//   clk_out     : divided clock, registered
//   rise_tick   : high in the cycle clk_out has just risen
//   fall_tick   : high in the cycle clk_out has just fallen
//   running     : 1 in RUN or STOPPING
//   active_div  : half-period ratio currently in use
module clock_divider_ctrl
    import clock_divider_ctrl_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    clock_divider_ctrl_if.slave cfg,
    output logic                clk_out,
    output logic                rise_tick,
    output logic                fall_tick,
    output logic                running,
    output logic [WIDTH-1:0]    active_div
);

    state_t           state_q, state_d;
    logic             clk_out_q, clk_out_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             running_q, running_d;
    logic             ready_q, ready_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;

    logic             accept;
    logic             div_zero;
    logic             take;
    logic             cnt_load;
    logic [WIDTH-1:0] cnt_value;
    logic             cnt_dec;
    logic             cnt_zero;

    clock_div_counter #(.WIDTH(WIDTH)) u_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (cnt_load),
        .load_value (cnt_value),
        .dec        (cnt_dec),
        .zero       (cnt_zero)
    );

    assign accept   = cfg.cfg_valid && ready_q;
    assign div_zero = (cfg.cfg_div == WIDTH'(DIV_ZERO));
    assign take     = accept && !div_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            clk_out_q  <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            running_q  <= 1'b0;
            ready_q    <= 1'b1;
            err_q      <= 1'b0;
            active_q   <= WIDTH'(DEFAULT_DIV);
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_out_q  <= clk_out_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            running_q  <= running_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            active_q   <= active_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clk_out_d  = clk_out_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        running_d  = running_q;
        ready_d    = ready_q;
        err_d      = accept && div_zero;
        active_d   = active_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        cnt_load   = 1'b0;
        cnt_value  = active_q - WIDTH'(1);
        cnt_dec    = 1'b0;

        unique case (state_q)
            IDLE: begin
                clk_out_d = 1'b0;
                if (take) begin
                    active_d = cfg.cfg_div;
                end
                if (en) begin
                    // A ratio accepted on the start edge governs the first high phase.
                    state_d   = RUN;
                    running_d = 1'b1;
                    clk_out_d = 1'b1;
                    rise_d    = 1'b1;
                    cnt_load  = 1'b1;
                    cnt_value = take ? (cfg.cfg_div - WIDTH'(1)) : (active_q - WIDTH'(1));
                end
            end

            RUN, STOPPING: begin
                if (state_q == RUN && !en) begin
                    state_d = STOPPING;
                end else if (state_q == STOPPING && en) begin
                    state_d = RUN;
                end

                // cfg_ready is low while a ratio is pending, so this never overwrites one.
                if (take) begin
                    pend_d     = cfg.cfg_div;
                    pend_vld_d = 1'b1;
                    ready_d    = 1'b0;
                end

                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else if (clk_out_q) begin
                    clk_out_d = 1'b0;
                    fall_d    = 1'b1;
                    cnt_load  = 1'b1;
                end else if (state_q == STOPPING && !en) begin
                    // Stop in place of the rise: clk_out is already low, so no runt pulse.
                    state_d   = IDLE;
                    running_d = 1'b0;
                    if (take) begin
                        active_d   = cfg.cfg_div;
                        pend_vld_d = 1'b0;
                        ready_d    = 1'b1;
                    end else if (pend_vld_q) begin
                        active_d   = pend_q;
                        pend_vld_d = 1'b0;
                        ready_d    = 1'b1;
                    end
                end else begin
                    clk_out_d = 1'b1;
                    rise_d    = 1'b1;
                    cnt_load  = 1'b1;
                    if (pend_vld_q) begin
                        active_d   = pend_q;
                        cnt_value  = pend_q - WIDTH'(1);
                        pend_vld_d = 1'b0;
                        ready_d    = 1'b1;
                    end
                end
            end

            default: begin
                state_d   = IDLE;
                running_d = 1'b0;
                clk_out_d = 1'b0;
            end
        endcase
    end

    assign clk_out       = clk_out_q;
    assign rise_tick     = rise_q;
    assign fall_tick     = fall_q;
    assign running       = running_q;
    assign active_div    = active_q;
    assign cfg.cfg_ready = ready_q;
    assign cfg.cfg_err   = err_q;

endmodule

// File: tb/tb_clock_divider_ctrl.sv
module tb_clock_divider_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             clk_out;
    logic             rise_tick;
    logic             fall_tick;
    logic             running;
    logic [WIDTH-1:0] active_div;

    int n_checks;
    int n_fail;

    clock_divider_ctrl_if #(.WIDTH(WIDTH)) cfg_if ();

    clock_divider_ctrl #(
        .WIDTH       (WIDTH),
        .DEFAULT_DIV (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .cfg        (cfg_if),
        .clk_out    (clk_out),
        .rise_tick  (rise_tick),
        .fall_tick  (fall_tick),
        .running    (running),
        .active_div (active_div)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n            = 1'b0;
        en               = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_div   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Offer a ratio in IDLE for one edge.
    task automatic load_div(input logic [WIDTH-1:0] d);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div   = d;
        step();
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n            = 1'b0;
        en               = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_div   = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({clk_out, rise_tick, fall_tick, running, cfg_if.cfg_ready, cfg_if.cfg_err} !== 6'b000010) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 000010", {clk_out, rise_tick, fall_tick, running, cfg_if.cfg_ready, cfg_if.cfg_err});
        end
        n_checks++;
        if (active_div !== 8'd2) begin
            n_fail++;
            $display("FAIL reset_active_div: got %0d required 2", active_div);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_default_run();
        logic [7:0] exp_clk, exp_rise, exp_fall;
        exp_clk  = 8'b11001100;
        exp_rise = 8'b10001000;
        exp_fall = 8'b00100010;
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            n_checks++;
            if ({clk_out, rise_tick, fall_tick} !== {exp_clk[7-i], exp_rise[7-i], exp_fall[7-i]}) begin
                n_fail++;
                $display("FAIL default_run cycle %0d: clk/rise/fall got %b required %b", i,
                         {clk_out, rise_tick, fall_tick}, {exp_clk[7-i], exp_rise[7-i], exp_fall[7-i]});
            end
        end
        n_checks++;
        if (active_div !== 8'd2 || running !== 1'b1) begin
            n_fail++;
            $display("FAIL default_run_state: active_div %0d running %b required 2 1", active_div, running);
        end
    endtask

    task automatic test_ratio_change();
        logic [14:0] exp_clk;
        exp_clk = 15'b100011111000001;
        do_reset();
        load_div(8'd3);
        n_checks++;
        if (active_div !== 8'd3 || cfg_if.cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_load: active_div %0d ready %b required 3 1", active_div, cfg_if.cfg_ready);
        end
        en = 1'b1;
        step();                       // edge 0: rise
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div   = 8'd5;
        step();                       // edge 1: accepted as pending
        cfg_if.cfg_valid = 1'b0;
        n_checks++;
        if (cfg_if.cfg_ready !== 1'b0 || active_div !== 8'd3) begin
            n_fail++;
            $display("FAIL pending_ready: ready %b active_div %0d required 0 3", cfg_if.cfg_ready, active_div);
        end
        for (int i = 0; i < 15; i++) begin
            step();                   // edge i+2
            n_checks++;
            if (clk_out !== exp_clk[14-i]) begin
                n_fail++;
                $display("FAIL ratio_change edge %0d: clk_out %b required %b", i + 2, clk_out, exp_clk[14-i]);
            end
            if (i == 3) begin
                n_checks++;
                if (cfg_if.cfg_ready !== 1'b0 || active_div !== 8'd3) begin
                    n_fail++;
                    $display("FAIL before_apply: ready %b active_div %0d required 0 3", cfg_if.cfg_ready, active_div);
                end
            end
            if (i == 4) begin
                n_checks++;
                if (cfg_if.cfg_ready !== 1'b1 || active_div !== 8'd5 || rise_tick !== 1'b1) begin
                    n_fail++;
                    $display("FAIL apply_edge: ready %b active_div %0d rise %b required 1 5 1",
                             cfg_if.cfg_ready, active_div, rise_tick);
                end
            end
        end
    endtask

    task automatic test_zero_reject();
        do_reset();
        load_div(8'd0);
        n_checks++;
        if (cfg_if.cfg_err !== 1'b1 || cfg_if.cfg_ready !== 1'b1 || active_div !== 8'd2) begin
            n_fail++;
            $display("FAIL zero_idle: err %b ready %b active_div %0d required 1 1 2",
                     cfg_if.cfg_err, cfg_if.cfg_ready, active_div);
        end
        step();
        n_checks++;
        if (cfg_if.cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_idle_pulse: err %b required 0", cfg_if.cfg_err);
        end
        en = 1'b1;
        step();                       // edge 0: rise
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div   = 8'd0;
        step();                       // edge 1
        cfg_if.cfg_valid = 1'b0;
        n_checks++;
        if (cfg_if.cfg_err !== 1'b1 || cfg_if.cfg_ready !== 1'b1 || clk_out !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_run: err %b ready %b clk_out %b required 1 1 1",
                     cfg_if.cfg_err, cfg_if.cfg_ready, clk_out);
        end
        step();                       // edge 2
        n_checks++;
        if (cfg_if.cfg_err !== 1'b0 || clk_out !== 1'b0 || active_div !== 8'd2) begin
            n_fail++;
            $display("FAIL zero_run_after: err %b clk_out %b active_div %0d required 0 0 2",
                     cfg_if.cfg_err, clk_out, active_div);
        end
        repeat (2) step();            // edge 4: rise with unchanged ratio
        n_checks++;
        if (rise_tick !== 1'b1 || cfg_if.cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_run_period: rise %b ready %b required 1 1", rise_tick, cfg_if.cfg_ready);
        end
    endtask

    task automatic test_stop();
        logic [8:0] exp_clk, exp_run;
        exp_clk = 9'b111000000;
        exp_run = 9'b111111100;
        do_reset();
        load_div(8'd4);
        en = 1'b1;
        step();                       // edge 0: rise
        en = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step();                   // edge i+1
            n_checks++;
            if ({clk_out, running, rise_tick} !== {exp_clk[8-i], exp_run[8-i], 1'b0}) begin
                n_fail++;
                $display("FAIL stop edge %0d: clk/running/rise %b required %b", i + 1,
                         {clk_out, running, rise_tick}, {exp_clk[8-i], exp_run[8-i], 1'b0});
            end
        end
    endtask

    task automatic test_stop_resume();
        logic [11:0] exp_clk;
        exp_clk = 12'b110001110001;
        do_reset();
        load_div(8'd3);
        en = 1'b1;
        step();                       // edge 0: rise
        for (int i = 1; i <= 12; i++) begin
            step();
            n_checks++;
            if (clk_out !== exp_clk[12-i] || running !== 1'b1) begin
                n_fail++;
                $display("FAIL stop_resume edge %0d: clk_out %b running %b required %b 1",
                         i, clk_out, running, exp_clk[12-i]);
            end
            if (i == 3) en = 1'b0;
            if (i == 4) en = 1'b1;
        end
    endtask

    task automatic test_div1_and_async_reset();
        do_reset();
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div   = 8'd1;
        en               = 1'b1;
        step();                       // edge 0: accept + start
        cfg_if.cfg_valid = 1'b0;
        n_checks++;
        if (active_div !== 8'd1 || clk_out !== 1'b1 || rise_tick !== 1'b1) begin
            n_fail++;
            $display("FAIL div1_start: active_div %0d clk_out %b rise %b required 1 1 1",
                     active_div, clk_out, rise_tick);
        end
        for (int i = 1; i < 6; i++) begin
            step();
            n_checks++;
            if ({clk_out, rise_tick, fall_tick} !== {~i[0], ~i[0], i[0]}) begin
                n_fail++;
                $display("FAIL div1 edge %0d: clk/rise/fall %b required %b", i,
                         {clk_out, rise_tick, fall_tick}, {~i[0], ~i[0], i[0]});
            end
        end
        step();                       // edge 6: clk_out high
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({clk_out, rise_tick, fall_tick, running, cfg_if.cfg_ready, cfg_if.cfg_err} !== 6'b000010
            || active_div !== 8'd2) begin
            n_fail++;
            $display("FAIL async_reset: ctrl %b active_div %0d required 000010 2",
                     {clk_out, rise_tick, fall_tick, running, cfg_if.cfg_ready, cfg_if.cfg_err}, active_div);
        end
        en = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        n_checks++;
        if (clk_out !== 1'b0 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: clk_out %b running %b required 0 0", clk_out, running);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_default_run();
        test_ratio_change();
        test_zero_reject();
        test_stop();
        test_stop_resume();
        test_div1_and_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
